rom_load_ctrl: RTL
==================

// Module: rom_load_ctrl
// PURPOSE
//  Downstream of the UART debug word assembler. Takes its one-cycle word-write strobes
//  (ce/wen/addr/data) and buffers them in a small FIFO. Converts the 1-based word index
//  to a byte address and writes the words into the instruction ROM over a req/ready port.
//  Holds the CPU in reset for the whole load session and reports word count, checksum,
//  overflow and completion.
// PARAMETERS
//  FIFO_DEPTH   4        entries in the word FIFO; power of 2, >=2
//  TIMEOUT_CYC  500000   idle cycles in LOAD, after >=1 word, that force DRAIN (0 disables)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active high
//  debug        in   1   load-session enable level from the debug switch
//  in_ce        in   1   word strobe chip enable (1-cycle pulse)
//  in_wen       in   1   word strobe write enable; word accepted when in_ce&in_wen
//  in_addr      in   32  1-based word index (first word of a session = 1)
//  in_data      in   32  word data, first received byte in [31:24]
//  rom_req      out  1   ROM write request
//  rom_addr     out  32  ROM byte address = (in_addr-1)<<2, mod 2^32
//  rom_wdata    out  32  ROM write data
//  rom_ready    in   1   ROM accepts write this cycle when rom_req&rom_ready
//  cpu_hold     out  1   CPU reset request, high during LOAD and DRAIN
//  load_done    out  1   1-cycle pulse when a session completes
//  word_count   out  16  words written to ROM this session; wraps at 2^16
//  checksum     out  32  mod-2^32 sum of rom_wdata of all completed writes this session
//  overflow     out  1   sticky: a strobe was dropped because the FIFO was full
// BEHAVIOUR
//  Reset:
//   - All outputs 0. FIFO empty. State IDLE. Debug-edge register 0. Timeout counter 0.
//  FSM states: IDLE, LOAD, DRAIN, DONE.
//   - IDLE->LOAD on debug rising edge (debug=1 while registered previous value=0).
//     On entry: word_count, checksum, overflow and timeout counter cleared; cpu_hold=1
//     from the next cycle.
//   - LOAD->DRAIN when debug=0, or when the timeout counter reaches TIMEOUT_CYC
//     with word_count+FIFO occupancy > 0.
//   - DRAIN->DONE when FIFO is empty and no handshake is pending.
//   - DONE: load_done=1 and cpu_hold=0 for exactly 1 cycle, then IDLE.
//   - A debug rising edge outside IDLE is ignored. A new session needs debug to fall and rise again.
//  Push:
//   - Only in LOAD, on in_ce&in_wen. Entry {(in_addr-1)<<2, in_data} is written at that edge.
//   - in_addr=0 gives address 0xFFFFFFFC; no error is raised.
//   - If the FIFO is full at that cycle, the entry is dropped and overflow<=1, even if a
//     pop occurs in the same cycle.
//   - Strobes in IDLE, DRAIN or DONE are ignored and do not set overflow.
//   - The timeout counter clears on every accepted or dropped strobe and saturates at TIMEOUT_CYC.
//  Pop / ROM port:
//   - rom_req, rom_addr and rom_wdata are registered and present the FIFO head.
//     rom_req=1 whenever the FIFO is non-empty in LOAD or DRAIN.
//   - Latency: strobe at edge N into an empty FIFO gives rom_req=1 after edge N+1.
//   - While rom_req=1 and rom_ready=0, rom_addr and rom_wdata hold stable.
//   - On rom_req&rom_ready: pop the entry, word_count+=1, checksum+=rom_wdata.
//     The next entry is presented in the following cycle, so back-to-back writes run at
//     1 word per 2 cycles minimum.
//   - Push and pop in the same cycle are both performed; occupancy is unchanged.
//  Other:
//   - Pointers are log2(FIFO_DEPTH) bits with an extra wrap bit; full and empty are
//     derived from the pointers. Pointers wrap cleanly.
//   - rst mid-session aborts immediately: FIFO flushed, rom_req=0 on the next cycle,
//     cpu_hold=0, no load_done pulse.
// TESTING
//  - Session, ready=1: debug 0->1, 3 strobes addr 1,2,3, data 0x00000013/0x00100093/0x00208113, debug->0
//    -> rom writes at 0x0,0x4,0x8 in order; word_count=3; checksum=0x003081B9; one load_done pulse;
//    cpu_hold low after DONE.
//  - Backpressure: rom_ready=0 for 20 cycles, 6 strobes, FIFO_DEPTH=4
//    -> first 4 entries buffered, strobes 5-6 dropped, overflow=1; after ready=1 exactly 4 writes
//    with addr/data stable during the stall.
//  - Timeout: TIMEOUT_CYC=100, 2 strobes then debug held at 1
//    -> DRAIN 100 cycles after the last strobe; load_done pulses; word_count=2.
//  - Ignored strobes: strobes in IDLE and in DRAIN -> no rom_req, word_count and overflow unchanged.
//  - Reset mid-load: rst high with 3 entries queued -> next cycle rom_req=0, cpu_hold=0,
//    word_count=0, no load_done; a new session starts clean.
//  - Edge case: strobe with in_addr=0, data 0xDEADBEEF -> rom_addr=0xFFFFFFFC, rom_wdata=0xDEADBEEF.

Source files
------------

// File: rtl/rom_load_ctrl.sv
// rtl/rom_load_ctrl.sv - buffers debug-loader word strobes and writes them into the instruction ROM
// Holds the CPU in reset while a load session is in progress and reports count/checksum/overflow.
module rom_load_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        debug,
    input  logic        in_ce,
    input  logic        in_wen,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_wdata,
    input  logic        rom_ready,
    output logic        cpu_hold,
    output logic        load_done,
    output logic [15:0] word_count,
    output logic [31:0] checksum,
    output logic        overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   debug_q;

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occupancy;
    logic          fifo_empty;
    logic          fifo_full;
    logic [63:0]   fifo_head;

    logic          rom_req_q, rom_req_d;
    logic [31:0]   rom_addr_q, rom_addr_d;
    logic [31:0]   rom_wdata_q, rom_wdata_d;

    logic [15:0]   word_count_q, word_count_d;
    logic [31:0]   checksum_q, checksum_d;
    logic          overflow_q, overflow_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          session_start;
    logic          active;
    logic          strobe;
    logic          push_ok;
    logic          fire;
    logic [16:0]   backlog;
    logic          timeout_hit;
    logic [31:0]   byte_addr;

    assign session_start = (state_q == S_IDLE) && debug && !debug_q;
    assign active        = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign strobe        = (state_q == S_LOAD) && in_ce && in_wen;
    assign push_ok       = strobe && !fifo_full;
    assign fire          = rom_req_q && rom_ready;
    assign byte_addr     = (in_addr - 32'd1) << 2;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign occupancy  = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

    assign backlog     = {1'b0, word_count_q} + 17'(occupancy);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (tmo_q == TMO_MAX) && (backlog != 17'd0);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            debug_q <= 1'b0;
        end else begin
            state_q <= state_d;
            debug_q <= debug;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (session_start) state_d = S_LOAD;
            S_LOAD:  if (!debug || timeout_hit) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty && !rom_req_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cpu_hold  = 1'b0;
        load_done = 1'b0;
        case (state_q)
            S_LOAD, S_DRAIN: cpu_hold  = 1'b1;
            S_DONE:          load_done = 1'b1;
            default:         ;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (push_ok ? (AW+1)'(1) : (AW+1)'(0));
        rd_ptr_d = rd_ptr_q + (fire    ? (AW+1)'(1) : (AW+1)'(0));
    end

    // After a completed write the port idles one cycle before presenting the next head.
    always_comb begin
        rom_req_d   = rom_req_q;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        if (fire) begin
            rom_req_d = 1'b0;
        end else if (!rom_req_q && active && !fifo_empty) begin
            rom_req_d   = 1'b1;
            rom_addr_d  = fifo_head[63:32];
            rom_wdata_d = fifo_head[31:0];
        end
    end

    always_comb begin
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        overflow_d   = overflow_q;
        tmo_d        = tmo_q;
        if (session_start) begin
            word_count_d = 16'd0;
            checksum_d   = 32'd0;
            overflow_d   = 1'b0;
            tmo_d        = '0;
        end else begin
            if (fire) begin
                word_count_d = word_count_q + 16'd1;
                checksum_d   = checksum_q + rom_wdata_q;
            end
            if (strobe && fifo_full) begin
                overflow_d = 1'b1;
            end
            if (state_q == S_LOAD) begin
                if (strobe) begin
                    tmo_d = '0;
                end else if (tmo_q != TMO_MAX) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rom_req_q    <= 1'b0;
            rom_addr_q   <= 32'd0;
            rom_wdata_q  <= 32'd0;
            word_count_q <= 16'd0;
            checksum_q   <= 32'd0;
            overflow_q   <= 1'b0;
            tmo_q        <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rom_req_q    <= rom_req_d;
            rom_addr_q   <= rom_addr_d;
            rom_wdata_q  <= rom_wdata_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            overflow_q   <= overflow_d;
            tmo_q        <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {byte_addr, in_data};
        end
    end

    assign rom_req    = rom_req_q;
    assign rom_addr   = rom_addr_q;
    assign rom_wdata  = rom_wdata_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;
    assign overflow   = overflow_q;

endmodule
